afifo_wctrl: RTL and testbench

Write-side controller for the team's asynchronous (dual-clock) FIFO, complementing the existing single-clock FIFO in the clock-transfer library. It runs entirely in the write clock domain and owns the binary/Gray write pointer. It synchronizes the read-domain Gray pointer and produces the RAM write enable/address, full, almost-full, occupancy and overflow indications. The read-side controller and the dual-port RAM instantiate alongside it.

---
 rtl/afifo_wctrl.sv | 43 ++++
 tb/tb_afifo_wctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/afifo_wctrl.sv
// afifo_wctrl: write-clock-domain half of an asynchronous FIFO.
// Owns the binary/Gray write pointer, synchronizes the read pointer, and registers full/level/overflow flags.
module afifo_wctrl #(
  parameter int DEPTH = 16,
  parameter int AFULL_TH = DEPTH - 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          wclk,
  input  logic          rst_n,
  input  logic          winc,
  input  logic [AW:0]   rptr_gray,
  output logic          wen,
  output logic [AW-1:0] waddr,
  output logic [AW:0]   wptr_gray,
  output logic          wfull,
  output logic          walmost_full,
  output logic [AW:0]   wlevel,
  output logic          wovf
);
  localparam logic [AW:0] TH = (AW+1)'(AFULL_TH);
  logic [AW:0] rq1, rq2, rbin_s, wbin, wbin_next, wgray_next, diff;
  assign wen = winc & ~wfull & rst_n;
  assign waddr = wbin[AW-1:0];
  // Each binary bit is the XOR of all Gray bits at or above it
  always_comb for (int i = 0; i <= AW; i++) rbin_s[i] = ^(rq2 >> i);
  assign wbin_next = wbin + (AW+1)'(wen);
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;
  assign diff = wbin_next - rbin_s;
  always_ff @(posedge wclk or negedge rst_n)
    if (!rst_n) begin
      {rq1, rq2, wbin, wptr_gray} <= '0;
      {wfull, walmost_full, wlevel, wovf} <= '0;
    end else begin
      rq1 <= rptr_gray;
      rq2 <= rq1;
      wbin <= wbin_next;
      wptr_gray <= wgray_next;
      wfull <= wgray_next == {~rq2[AW:AW-1], rq2[AW-2:0]};
      walmost_full <= diff >= TH;
      wlevel <= diff;
      wovf <= wovf | (winc & wfull);
    end
endmodule

// File: tb/tb_afifo_wctrl.sv
// tb_afifo_wctrl: scenario tasks checking afifo_wctrl against a count-based occupancy model.
module tb_afifo_wctrl;
  logic wclk = 0, rst_n = 0, winc = 0, winc8 = 0;
  logic [4:0] rptr_gray, wptr_gray, wlevel;
  logic [3:0] waddr, rptr8 = 0, wgray8, wlvl8;
  logic [2:0] waddr8;
  logic wen, wfull, walmost_full, wovf, wen8, wfull8, wal8, wovf8;
  int rcnt = 0, errs = 0, checks = 0;

  function automatic int g(int b);
    return b ^ (b >> 1);
  endfunction

  assign rptr_gray = 5'(g(rcnt % 32));

  afifo_wctrl dut (.wclk(wclk), .rst_n(rst_n), .winc(winc), .rptr_gray(rptr_gray), .wen(wen),
    .waddr(waddr), .wptr_gray(wptr_gray), .wfull(wfull), .walmost_full(walmost_full),
    .wlevel(wlevel), .wovf(wovf));

  afifo_wctrl #(.DEPTH(8), .AFULL_TH(5)) u8 (.wclk(wclk), .rst_n(rst_n), .winc(winc8),
    .rptr_gray(rptr8), .wen(wen8), .waddr(waddr8), .wptr_gray(wgray8), .wfull(wfull8),
    .walmost_full(wal8), .wlevel(wlvl8), .wovf(wovf8));

  always #5 wclk = ~wclk;

  // Model: count of accepted writes vs. the read count as it was two edges ago
  int m_w = 0, m_q1 = 0, m_q2 = 0, m_lvl = 0;
  bit m_full = 0, m_af = 0, m_ovf = 0;
  always @(posedge wclk or negedge rst_n) begin
    int nw, nl;
    if (!rst_n) begin
      m_w <= 0; m_q1 <= 0; m_q2 <= 0; m_lvl <= 0;
      m_full <= 0; m_af <= 0; m_ovf <= 0;
    end else begin
      nw = (m_w + ((winc && !m_full) ? 1 : 0)) % 32;
      nl = ((nw - m_q2) % 32 + 32) % 32;
      m_w <= nw;
      m_lvl <= nl;
      m_full <= nl == 16;
      m_af <= nl >= 14;
      m_ovf <= m_ovf | (winc && m_full);
      m_q1 <= rcnt;
      m_q2 <= m_q1;
    end
  end

  task automatic step;
    @(posedge wclk);
    @(negedge wclk);
  endtask

  task automatic test_reset;
    winc = 1;
    @(posedge wclk);
    #1;
    checks++; if (wen !== 1'b0) begin errs++; $display("FAIL reset_wen got=%b exp=0", wen); end
    checks++; if ({waddr, wptr_gray, wfull, walmost_full, wlevel, wovf} !== '0) begin
      errs++; $display("FAIL reset_outs got=%h exp=0", {waddr, wptr_gray, wfull, walmost_full, wlevel, wovf}); end
    winc = 0;
    @(negedge wclk);
    rst_n = 1;
  endtask

  task automatic test_fill;
    rcnt = 0;
    for (int i = 0; i < 16; i++) begin
      winc = 1;
      #1;
      checks++; if (waddr !== 4'(i)) begin errs++; $display("FAIL fill_waddr i=%0d got=%0d exp=%0d", i, waddr, i); end
      checks++; if (wptr_gray !== 5'(g(i))) begin errs++; $display("FAIL fill_gray i=%0d got=%b exp=%b", i, wptr_gray, 5'(g(i))); end
      checks++; if (wen !== 1'b1) begin errs++; $display("FAIL fill_wen i=%0d got=%b exp=1", i, wen); end
      step;
      checks++; if (wlevel !== 5'(i + 1)) begin errs++; $display("FAIL fill_level i=%0d got=%0d exp=%0d", i, wlevel, i + 1); end
      checks++; if (walmost_full !== (i + 1 >= 14)) begin errs++; $display("FAIL fill_afull i=%0d got=%b exp=%b", i, walmost_full, i + 1 >= 14); end
      checks++; if (wfull !== (i == 15)) begin errs++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, wfull, i == 15); end
    end
    winc = 0;
    checks++; if (wptr_gray !== 5'b11000) begin errs++; $display("FAIL fill_gray_end got=%b exp=11000", wptr_gray); end
  endtask

  task automatic test_overflow;
    winc = 1;
    #1;
    checks++; if (wen !== 1'b0) begin errs++; $display("FAIL ovf_wen got=%b exp=0", wen); end
    step;
    winc = 0;
    checks++; if (wptr_gray !== 5'b11000) begin errs++; $display("FAIL ovf_gray got=%b exp=11000", wptr_gray); end
    checks++; if (wovf !== 1'b1) begin errs++; $display("FAIL ovf_set got=%b exp=1", wovf); end
    step;
    checks++; if (wovf !== 1'b1) begin errs++; $display("FAIL ovf_sticky got=%b exp=1", wovf); end
    checks++; if (wlevel !== 5'd16) begin errs++; $display("FAIL ovf_level got=%0d exp=16", wlevel); end
  endtask

  task automatic test_drain;
    rcnt = 4;
    for (int e = 1; e <= 3; e++) begin
      step;
      checks++; if (wfull !== (e < 3)) begin errs++; $display("FAIL drain_full edge=%0d got=%b exp=%b", e, wfull, e < 3); end
    end
    checks++; if (wlevel !== 5'd12) begin errs++; $display("FAIL drain_level got=%0d exp=12", wlevel); end
    checks++; if (walmost_full !== 1'b0) begin errs++; $display("FAIL drain_afull got=%b exp=0", walmost_full); end
  endtask

  task automatic test_wrap;
    int n = 0, d1 = m_w, d2 = m_w;
    bit acc, wrapped = 0;
    logic [4:0] prev = wptr_gray;
    for (int c = 0; c < 300 && n < 40; c++) begin
      winc = $urandom_range(0, 3) != 0;
      #1;
      acc = winc && !m_full;
      step;
      n += acc ? 1 : 0;
      checks++; if (wptr_gray !== 5'(g(m_w))) begin errs++; $display("FAIL wrap_gray c=%0d got=%b exp=%b", c, wptr_gray, 5'(g(m_w))); end
      checks++; if (wfull !== 1'b0) begin errs++; $display("FAIL wrap_full c=%0d got=%b exp=0", c, wfull); end
      checks++; if ($countones(prev ^ wptr_gray) != (acc ? 1 : 0)) begin
        errs++; $display("FAIL wrap_onebit c=%0d prev=%b cur=%b acc=%b", c, prev, wptr_gray, acc); end
      checks++; if (wlevel !== 5'(m_lvl)) begin errs++; $display("FAIL wrap_level c=%0d got=%0d exp=%0d", c, wlevel, m_lvl); end
      if (prev == 5'b10000 && wptr_gray == 5'b00000) wrapped = 1;
      prev = wptr_gray;
      rcnt = d2; d2 = d1; d1 = m_w;
    end
    winc = 0;
    checks++; if (n != 40) begin errs++; $display("FAIL wrap_count got=%0d exp=40", n); end
    checks++; if (!wrapped) begin errs++; $display("FAIL wrap_seen got=0 exp=1"); end
  endtask

  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      winc = $urandom_range(0, 3) < ((c < 200) ? 3 : 1);
      if (((m_w - rcnt + 32) % 32) > 0 && $urandom_range(0, 3) < ((c < 200) ? 1 : 3)) rcnt = (rcnt + 1) % 32;
      #1;
      checks++; if (wen !== (winc && !m_full)) begin errs++; $display("FAIL rnd_wen c=%0d got=%b exp=%b", c, wen, winc && !m_full); end
      step;
      checks++; if ({waddr, wptr_gray} !== {4'(m_w), 5'(g(m_w))}) begin
        errs++; $display("FAIL rnd_ptr c=%0d got=%h/%b exp=%h/%b", c, waddr, wptr_gray, 4'(m_w), 5'(g(m_w))); end
      checks++; if ({wfull, walmost_full, wlevel, wovf} !== {m_full, m_af, 5'(m_lvl), m_ovf}) begin
        errs++; $display("FAIL rnd_flags c=%0d got=%b%b/%0d/%b exp=%b%b/%0d/%b", c, wfull, walmost_full, wlevel, wovf,
          m_full, m_af, m_lvl, m_ovf); end
    end
    winc = 0;
  endtask

  task automatic test_reset_mid;
    rcnt = m_w;
    repeat (3) step;
    for (int i = 0; i < 9; i++) begin winc = 1; step; end
    winc = 0;
    checks++; if (wlevel !== 5'd9) begin errs++; $display("FAIL mid_level9 got=%0d exp=9", wlevel); end
    @(posedge wclk);
    #3 rst_n = 0;
    #1;
    checks++; if ({waddr, wptr_gray, wfull, walmost_full, wlevel, wovf} !== '0) begin
      errs++; $display("FAIL mid_clear got=%h exp=0", {waddr, wptr_gray, wfull, walmost_full, wlevel, wovf}); end
    winc = 1;
    rcnt = 0;
    #1;
    checks++; if (wen !== 1'b0) begin errs++; $display("FAIL mid_wen got=%b exp=0", wen); end
    step;
    checks++; if (wlevel !== 5'd0 || wen !== 1'b0) begin errs++; $display("FAIL mid_hold level=%0d wen=%b exp=0/0", wlevel, wen); end
    rst_n = 1;
    #1;
    checks++; if (waddr !== 4'd0 || wen !== 1'b1) begin errs++; $display("FAIL mid_first waddr=%0d wen=%b exp=0/1", waddr, wen); end
    step;
    winc = 0;
    checks++; if (wlevel !== 5'd1 || wptr_gray !== 5'b00001) begin
      errs++; $display("FAIL mid_after level=%0d gray=%b exp=1/00001", wlevel, wptr_gray); end
  endtask

  task automatic test_threshold;
    for (int k = 1; k <= 5; k++) begin
      winc8 = 1;
      step;
      checks++; if (wal8 !== (k >= 5)) begin errs++; $display("FAIL th_rise k=%0d got=%b exp=%b", k, wal8, k >= 5); end
    end
    winc8 = 0;
    checks++; if (wlvl8 !== 4'd5) begin errs++; $display("FAIL th_level5 got=%0d exp=5", wlvl8); end
    rptr8 = 4'b0001;
    for (int e = 1; e <= 3; e++) begin
      step;
      checks++; if (wal8 !== (e < 3)) begin errs++; $display("FAIL th_fall edge=%0d got=%b exp=%b", e, wal8, e < 3); end
    end
    checks++; if (wlvl8 !== 4'd4) begin errs++; $display("FAIL th_level4 got=%0d exp=4", wlvl8); end
  endtask

  initial begin
    test_reset;
    @(negedge wclk);
    test_fill;
    test_overflow;
    test_drain;
    test_wrap;
    test_random;
    test_reset_mid;
    test_threshold;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
